// File: rtl/incdec_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// incdec_arbiter_pkg : shared opcodes, FSM encoding and defaults
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package incdec_arbiter_pkg;

  localparam logic OP_DEC = 1'b0;
  localparam logic OP_INC = 1'b1;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/Incre_Decre.sv
// ----------------------------------------------------------------------------
// Incre_Decre : combinational increment (sel=1) / decrement (sel=0), modulo 2^WIDTH
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module Incre_Decre #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic             i_sel,
  output logic [WIDTH-1:0] o_y
);

  assign o_y = i_sel ? (i_a + WIDTH'(1)) : (i_a - WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick, first request at or above i_ptr
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  logic [NREQ-1:0] w_rot;
  int              w_off;
  int              w_pos;

  // Rotate so that bit 0 is the requester at i_ptr; the lowest set bit wins.
  assign w_rot = NREQ'({i_req, i_req} >> i_ptr);

  always_comb begin
    w_off = 0;
    o_any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = k;
        o_any = 1'b1;
      end
    end
    w_pos = int'(i_ptr) + w_off;
    if (w_pos >= NREQ) begin
      w_pos = w_pos - NREQ;
    end
    o_idx   = IDW'(w_pos);
    o_grant = '0;
    for (int k = 0; k < NREQ; k++) begin
      o_grant[k] = o_any && (o_idx == IDW'(k));
    end
  end

endmodule

`default_nettype wire

// File: rtl/incdec_arbiter.sv
// ----------------------------------------------------------------------------
// incdec_arbiter : round-robin sharing of one Incre_Decre unit among NREQ clients
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module incdec_arbiter
  import incdec_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       i_req_valid,
  output logic [NREQ-1:0]       o_req_ready,
  input  logic [NREQ*WIDTH-1:0] i_req_a,
  input  logic [NREQ-1:0]       i_req_sel,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [WIDTH-1:0]      o_rsp_data,
  output logic [IDW-1:0]        o_rsp_id,
  output logic                  o_rsp_wrap
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [IDW-1:0]   r_rr_ptr;
  logic [WIDTH-1:0] r_op_a;
  logic             r_op_sel;
  logic [IDW-1:0]   r_op_id;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;
  logic [IDW-1:0]   r_rsp_id;
  logic             r_rsp_wrap;

  logic [NREQ-1:0]  w_grant;
  logic [IDW-1:0]   w_gnt_idx;
  logic             w_gnt_any;
  logic [NREQ-1:0]  w_req_ready;
  logic             w_capture;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_idec_y;
  logic             w_wrap;
  logic [IDW-1:0]   w_ptr_nxt;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .i_req   (i_req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gnt_idx),
    .o_any   (w_gnt_any)
  );

  Incre_Decre #(
    .WIDTH (WIDTH)
  ) u_incre_decre (
    .i_a   (r_op_a),
    .i_sel (r_op_sel),
    .o_y   (w_idec_y)
  );

  assign w_sel_a   = i_req_a[int'(w_gnt_idx)*WIDTH +: WIDTH];
  assign w_wrap    = (r_op_sel == OP_INC) ? (&r_op_a) : ~(|r_op_a);
  assign w_ptr_nxt = (r_op_id == IDW'(NREQ - 1)) ? '0 : (r_op_id + IDW'(1));

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = '0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_any) begin
          w_req_ready = w_grant;
          w_capture   = 1'b1;
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_op_a      <= '0;
      r_op_sel    <= OP_DEC;
      r_op_id     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_rsp_wrap  <= 1'b0;
    end else begin
      if (w_capture) begin
        r_op_a   <= w_sel_a;
        r_op_sel <= i_req_sel[w_gnt_idx];
        r_op_id  <= w_gnt_idx;
      end
      if (r_state == ST_EXEC) begin
        r_rsp_data  <= w_idec_y;
        r_rsp_wrap  <= w_wrap;
        r_rsp_id    <= r_op_id;
        r_rsp_valid <= 1'b1;
        r_rr_ptr    <= w_ptr_nxt;
      end else if ((r_state == ST_RESP) && i_rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  // Suppress grants while reset is held, since IDLE is combinationally live then.
  assign o_req_ready = w_req_ready & {NREQ{rst_n}};
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_wrap  = r_rsp_wrap;

endmodule

`default_nettype wire

// File: tb/tb_incdec_arbiter.sv
// ----------------------------------------------------------------------------
// tb_incdec_arbiter : scoreboard bench for incdec_arbiter with a behavioural model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_incdec_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ-1:0]       req_sel;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_data;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_wrap;
  logic [WIDTH-1:0]      a_arr [NREQ];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_a[g*WIDTH +: WIDTH] = a_arr[g];
  end

  incdec_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_a     (req_a),
    .i_req_sel   (req_sel),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_data  (rsp_data),
    .o_rsp_id    (rsp_id),
    .o_rsp_wrap  (rsp_wrap)
  );

  typedef struct {
    int id;
    int data;
    int wrap;
  } exp_t;

  exp_t            q[$];
  int              id_log[$];
  int              checks = 0;
  int              errors = 0;
  bit              mon_en = 1'b0;
  bit              busy = 1'b0;
  bit              prev_valid = 1'b0;
  bit              prev_stall = 1'b0;
  int              prev_data, prev_id, prev_wrap;
  int              last_srv = NREQ - 1;
  int              grant_cyc = 0;
  int              cyc = 0;
  logic [NREQ-1:0] granted = '0;

  function automatic void chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Reference: the requester after the last one served has top priority.
  function automatic int pick(logic [NREQ-1:0] v, int last);
    for (int k = 1; k <= NREQ; k++) begin
      int j = (last + k) % NREQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      last_srv   = NREQ - 1;
      busy       = 1'b0;
      prev_valid = 1'b0;
      prev_stall = 1'b0;
      granted    = '0;
    end else begin
      granted = req_ready;
      if (mon_en) begin
        int eg;
        int ev;
        eg = busy ? -1 : pick(req_valid, last_srv);
        ev = (eg < 0) ? 0 : (1 << eg);
        chk("req_ready", int'(req_ready), ev);
        if (eg >= 0 && int'(req_ready) == ev) begin
          exp_t e;
          int   a;
          a      = int'(a_arr[eg]);
          e.id   = eg;
          e.data = req_sel[eg] ? (a + 1) % 256 : (a + 255) % 256;
          e.wrap = (req_sel[eg] && a == 255) || (!req_sel[eg] && a == 0) ? 1 : 0;
          q.push_back(e);
          last_srv  = eg;
          busy      = 1'b1;
          grant_cyc = cyc;
        end
        if (prev_stall) begin
          chk("rsp_hold_valid", int'(rsp_valid), 1);
          chk("rsp_hold_data", int'(rsp_data), prev_data);
          chk("rsp_hold_id", int'(rsp_id), prev_id);
          chk("rsp_hold_wrap", int'(rsp_wrap), prev_wrap);
        end else if (prev_valid) begin
          chk("rsp_clear", int'(rsp_valid), 0);
        end
        if (rsp_valid && !prev_valid) chk("rsp_latency", cyc - grant_cyc, 2);
        if (busy && !rsp_valid && (cyc - grant_cyc) >= 2) chk("rsp_late", int'(rsp_valid), 1);
        if (rsp_valid && rsp_ready) begin
          if (q.size() == 0) begin
            chk("rsp_unexpected_q", q.size(), 1);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("rsp_data", int'(rsp_data), e.data);
            chk("rsp_id", int'(rsp_id), e.id);
            chk("rsp_wrap", int'(rsp_wrap), e.wrap);
            id_log.push_back(int'(rsp_id));
            busy = 1'b0;
          end
        end
      end
      prev_valid = rsp_valid;
      prev_stall = rsp_valid && !rsp_ready;
      prev_data  = int'(rsp_data);
      prev_id    = int'(rsp_id);
      prev_wrap  = int'(rsp_wrap);
    end
  end

  task automatic issue(int i, logic [WIDTH-1:0] a, logic sel);
    bit got = 1'b0;
    @(posedge clk); #2;
    a_arr[i]     = a;
    req_sel[i]   = sel;
    req_valid[i] = 1'b1;
    for (int n = 0; n < 50 && !got; n++) begin
      @(posedge clk); #2;
      if (granted[i]) begin
        req_valid[i] = 1'b0;
        got = 1'b1;
      end
    end
    chk("issue_grant_seen", int'(got), 1);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(posedge clk); #2;
      if (!busy && q.size() == 0 && !rsp_valid) done = 1'b1;
    end
    chk("wait_idle_done", int'(done), 1);
  endtask

  task automatic apply_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  function automatic logic [WIDTH-1:0] rand_a();
    case ($urandom_range(3))
      0:       return '0;
      1:       return '1;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  initial begin
    int base;
    bit ok;
    rst_n     = 1'b1;
    req_valid = '0;
    req_sel   = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) a_arr[i] = '0;
    #1 rst_n = 1'b0;
    req_valid = '1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_rsp_data", int'(rsp_data), 0);
    chk("reset_rsp_id", int'(rsp_id), 0);
    chk("reset_rsp_wrap", int'(rsp_wrap), 0);
    chk("reset_req_ready", int'(req_ready), 0);
    req_valid = '0;
    @(posedge clk); #2;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    rsp_ready = 1'b1;

    // Single increment, then the wrap cases
    issue(0, 8'h05, 1'b1); wait_idle();
    issue(0, 8'hFF, 1'b1); wait_idle();
    issue(1, 8'h00, 1'b0); wait_idle();
    issue(2, 8'h85, 1'b0); wait_idle();

    // Round robin from reset with all requesters held active
    apply_reset();
    base = id_log.size();
    @(posedge clk); #2;
    for (int i = 0; i < NREQ; i++) a_arr[i] = rand_a();
    req_valid = '1;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(posedge clk); #2;
      for (int i = 0; i < NREQ; i++) if (granted[i]) a_arr[i] = rand_a();
      if (id_log.size() >= base + 5) ok = 1'b1;
    end
    req_valid = '0;
    wait_idle();
    chk("rr_enough_rsps", int'(ok), 1);
    for (int k = 0; k < 5 && ok; k++) chk("rr_id_seq", id_log[base + k], k % NREQ);

    // Backpressure with other requesters pending
    @(posedge clk); #2;
    rsp_ready = 1'b0;
    req_valid = '1;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(posedge clk); #2;
      if (rsp_valid) ok = 1'b1;
    end
    chk("bp_rsp_seen", int'(ok), 1);
    repeat (10) @(posedge clk);
    #2;
    rsp_ready = 1'b1;
    base = id_log.size();
    for (int n = 0; n < 40 && id_log.size() < base + 3; n++) begin
      @(posedge clk); #2;
      for (int i = 0; i < NREQ; i++) if (granted[i]) a_arr[i] = rand_a();
    end
    req_valid = '0;
    wait_idle();

    // Sparse requests
    base = id_log.size();
    issue(2, 8'h10, 1'b1); wait_idle();
    issue(0, 8'h20, 1'b0); wait_idle();
    chk("sparse_count", id_log.size() - base, 2);
    if (id_log.size() >= base + 2) begin
      chk("sparse_first", id_log[base], 2);
      chk("sparse_second", id_log[base + 1], 0);
    end

    // Randomized traffic
    repeat (3000) begin
      @(posedge clk); #2;
      for (int i = 0; i < NREQ; i++) begin
        if (granted[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(3) == 0) begin
          req_valid[i] = 1'b1;
          a_arr[i]     = rand_a();
          req_sel[i]   = 1'($urandom_range(1));
        end else if (req_valid[i] && !granted[i] && $urandom_range(63) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(2) != 0);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle();

    // Reset during EXEC discards the operation and restarts the pointer
    @(posedge clk); #2;
    mon_en    = 1'b0;
    a_arr[3]  = 8'h33;
    req_sel[3] = 1'b1;
    req_valid = 4'b1000;
    ok = 1'b0;
    for (int n = 0; n < 10 && !ok; n++) begin
      @(posedge clk); #2;
      if (granted[3]) ok = 1'b1;
    end
    chk("midrst_grant", int'(ok), 1);
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid_now", int'(rsp_valid), 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    req_valid = '1;
    #1;
    chk("midrst_next_grant", int'(req_ready), 1);
    req_valid = '0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("midrst_no_rsp", int'(rsp_valid), 0);
    end

    // Reset while a response is being held clears it asynchronously
    @(posedge clk); #2;
    rsp_ready  = 1'b0;
    a_arr[1]   = 8'h41;
    req_sel[1] = 1'b0;
    req_valid  = 4'b0010;
    ok = 1'b0;
    for (int n = 0; n < 10 && !ok; n++) begin
      @(posedge clk); #2;
      if (granted[1]) req_valid = '0;
      if (rsp_valid) ok = 1'b1;
    end
    chk("resprst_valid_seen", int'(ok), 1);
    chk("resprst_data_before", int'(rsp_data), 8'h40);
    rst_n = 1'b0;
    #1;
    chk("resprst_valid_now", int'(rsp_valid), 0);
    chk("resprst_data_now", int'(rsp_data), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout actual=%0t required=finish", $time);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
